// File: rtl/plab5_mcore_line2word_trans.sv
// Line-to-word memory translator: splits each 16-byte line request into four
// word requests on a narrow port and reassembles the word responses into one line response.

`ifndef VC_MEM_MSGS_V
`define VC_MEM_MSGS_V
`define VC_MEM_LEN_NB(d_) $clog2((d_)/8)
`define VC_MEM_REQ_MSG_NBITS(o_,a_,d_) (3+(o_)+(a_)+`VC_MEM_LEN_NB(d_)+(d_))
`define VC_MEM_REQ_MSG_DATA_FIELD(o_,a_,d_) ((d_)-1):0
`define VC_MEM_REQ_MSG_LEN_FIELD(o_,a_,d_) ((d_)+`VC_MEM_LEN_NB(d_)-1):(d_)
`define VC_MEM_REQ_MSG_ADDR_FIELD(o_,a_,d_) ((d_)+`VC_MEM_LEN_NB(d_)+(a_)-1):((d_)+`VC_MEM_LEN_NB(d_))
`define VC_MEM_REQ_MSG_OPAQUE_FIELD(o_,a_,d_) ((d_)+`VC_MEM_LEN_NB(d_)+(a_)+(o_)-1):((d_)+`VC_MEM_LEN_NB(d_)+(a_))
`define VC_MEM_REQ_MSG_TYPE_FIELD(o_,a_,d_) ((d_)+`VC_MEM_LEN_NB(d_)+(a_)+(o_)+2):((d_)+`VC_MEM_LEN_NB(d_)+(a_)+(o_))
`define VC_MEM_RESP_MSG_NBITS(o_,d_) (3+(o_)+`VC_MEM_LEN_NB(d_)+(d_))
`define VC_MEM_RESP_MSG_DATA_FIELD(o_,d_) ((d_)-1):0
`define VC_MEM_RESP_MSG_LEN_FIELD(o_,d_) ((d_)+`VC_MEM_LEN_NB(d_)-1):(d_)
`define VC_MEM_RESP_MSG_OPAQUE_FIELD(o_,d_) ((d_)+`VC_MEM_LEN_NB(d_)+(o_)-1):((d_)+`VC_MEM_LEN_NB(d_))
`define VC_MEM_RESP_MSG_TYPE_FIELD(o_,d_) ((d_)+`VC_MEM_LEN_NB(d_)+(o_)+2):((d_)+`VC_MEM_LEN_NB(d_)+(o_))
`endif

module plab5_mcore_line2word_trans #(
  parameter int opaque_nbits    = 8,
  parameter int addr_nbits      = 32,
  parameter int proc_data_nbits = 32,
  parameter int mem_data_nbits  = 128,
  localparam int WREQ_NB  = `VC_MEM_REQ_MSG_NBITS(opaque_nbits, addr_nbits, mem_data_nbits),
  localparam int WRESP_NB = `VC_MEM_RESP_MSG_NBITS(opaque_nbits, mem_data_nbits),
  localparam int NREQ_NB  = `VC_MEM_REQ_MSG_NBITS(opaque_nbits, addr_nbits, proc_data_nbits),
  localparam int NRESP_NB = `VC_MEM_RESP_MSG_NBITS(opaque_nbits, proc_data_nbits)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                wreq_val_i,
  output logic                wreq_rdy_o,
  input  logic [WREQ_NB-1:0]  wreq_msg_i,
  output logic                wresp_val_o,
  input  logic                wresp_rdy_i,
  output logic [WRESP_NB-1:0] wresp_msg_o,
  output logic                nreq_val_o,
  input  logic                nreq_rdy_i,
  output logic [NREQ_NB-1:0]  nreq_msg_o,
  input  logic                nresp_val_i,
  output logic                nresp_rdy_o,
  input  logic [NRESP_NB-1:0] nresp_msg_i
);

  localparam int O  = opaque_nbits;
  localparam int A  = addr_nbits;
  localparam int PD = proc_data_nbits;
  localparam int MD = mem_data_nbits;
  localparam int LB = `VC_MEM_LEN_NB(MD);

  typedef enum logic [1:0] {IDLE, NREQ, NWAIT, WRESP} state_e;

  state_e          state_q, state_d;
  logic [1:0]      beat_q, beat_d;
  logic [2:0]      type_q, type_d;
  logic [O-1:0]    opq_q, opq_d;
  logic [A-1:0]    addr_q, addr_d;
  logic [MD-1:0]   wdata_q, wdata_d;
  logic [MD-1:0]   buf_q, buf_d;

  logic [A-1:0]    w_addr;
  logic            is_wr;
  logic            unused_bits;

  assign w_addr = wreq_msg_i[`VC_MEM_REQ_MSG_ADDR_FIELD(O, A, MD)];
  // Only a write (type 1) carries data; every other type assembles like a read.
  assign is_wr  = (type_q == 3'd1);

  // Wide len, low address bits and narrow response type/opaque/len carry no information here.
  assign unused_bits = ^{wreq_msg_i[`VC_MEM_REQ_MSG_LEN_FIELD(O, A, MD)], w_addr[LB-1:0],
                         nresp_msg_i[`VC_MEM_RESP_MSG_TYPE_FIELD(O, PD)],
                         nresp_msg_i[`VC_MEM_RESP_MSG_OPAQUE_FIELD(O, PD)],
                         nresp_msg_i[`VC_MEM_RESP_MSG_LEN_FIELD(O, PD)]};

  assign wreq_rdy_o  = (state_q == IDLE);
  assign nreq_val_o  = (state_q == NREQ);
  assign nresp_rdy_o = (state_q == NWAIT);
  assign wresp_val_o = (state_q == WRESP);

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    type_d  = type_q;
    opq_d   = opq_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: if (wreq_val_i) begin
        type_d  = wreq_msg_i[`VC_MEM_REQ_MSG_TYPE_FIELD(O, A, MD)];
        opq_d   = wreq_msg_i[`VC_MEM_REQ_MSG_OPAQUE_FIELD(O, A, MD)];
        addr_d  = {w_addr[A-1:LB], {LB{1'b0}}};
        wdata_d = wreq_msg_i[`VC_MEM_REQ_MSG_DATA_FIELD(O, A, MD)];
        beat_d  = 2'd0;
        state_d = NREQ;
      end
      NREQ: if (nreq_rdy_i) state_d = NWAIT;
      NWAIT: if (nresp_val_i) begin
        buf_d[int'(beat_q)*PD +: PD] = nresp_msg_i[`VC_MEM_RESP_MSG_DATA_FIELD(O, PD)];
        if (beat_q == 2'd3) begin
          state_d = WRESP;
        end else begin
          beat_d  = beat_q + 2'd1;
          state_d = NREQ;
        end
      end
      WRESP: if (wresp_rdy_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      beat_q  <= '0;
      type_q  <= '0;
      opq_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      type_q  <= type_d;
      opq_q   <= opq_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
    end
  end

  // Messages are pure functions of latched state, so they hold steady under back-pressure.
  always_comb begin
    nreq_msg_o = '0;
    nreq_msg_o[`VC_MEM_REQ_MSG_TYPE_FIELD(O, A, PD)]   = type_q;
    nreq_msg_o[`VC_MEM_REQ_MSG_OPAQUE_FIELD(O, A, PD)] = opq_q;
    nreq_msg_o[`VC_MEM_REQ_MSG_ADDR_FIELD(O, A, PD)]   = addr_q + A'(beat_q) * A'(PD/8);
    nreq_msg_o[`VC_MEM_REQ_MSG_DATA_FIELD(O, A, PD)]   = is_wr ? wdata_q[int'(beat_q)*PD +: PD] : '0;
  end

  always_comb begin
    wresp_msg_o = '0;
    wresp_msg_o[`VC_MEM_RESP_MSG_TYPE_FIELD(O, MD)]   = type_q;
    wresp_msg_o[`VC_MEM_RESP_MSG_OPAQUE_FIELD(O, MD)] = opq_q;
    wresp_msg_o[`VC_MEM_RESP_MSG_DATA_FIELD(O, MD)]   = is_wr ? '0 : buf_q;
  end

endmodule

// File: tb/tb_plab5_mcore_line2word_trans.sv
// Randomized self-checking bench for the line-to-word translator against a line-level reference model.

module tb_plab5_mcore_line2word_trans;

  localparam int WRQ = 175;  // {type3, opq8, addr32, len4, data128}
  localparam int WRS = 143;  // {type3, opq8, len4, data128}
  localparam int NRQ = 77;   // {type3, opq8, addr32, len2, data32}
  localparam int NRS = 45;   // {type3, opq8, len2, data32}

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_n;
  logic           wreq_val, wreq_rdy, wresp_val, wresp_rdy;
  logic           nreq_val, nreq_rdy, nresp_val, nresp_rdy;
  logic [WRQ-1:0] wreq_msg;
  logic [WRS-1:0] wresp_msg;
  logic [NRQ-1:0] nreq_msg;
  logic [NRS-1:0] nresp_msg;

  plab5_mcore_line2word_trans dut (
    .clk_i(clk), .reset_i(reset_n),
    .wreq_val_i(wreq_val), .wreq_rdy_o(wreq_rdy), .wreq_msg_i(wreq_msg),
    .wresp_val_o(wresp_val), .wresp_rdy_i(wresp_rdy), .wresp_msg_o(wresp_msg),
    .nreq_val_o(nreq_val), .nreq_rdy_i(nreq_rdy), .nreq_msg_o(nreq_msg),
    .nresp_val_i(nresp_val), .nresp_rdy_o(nresp_rdy), .nresp_msg_i(nresp_msg)
  );

  int checks = 0;
  int failures = 0;

  // Stimulus knobs for the transaction driver
  logic [127:0]   k_line;     // words the narrow memory returns, word i at bits 32i+
  int             k_nst[4];   // cycles to hold nreq_rdy low per beat
  int             k_rdl[4];   // cycles to delay nresp_val per beat
  int             k_wst;      // cycles to hold wresp_rdy low
  int             k_abort;    // stop in NWAIT of this beat (-1 = never)
  bit             k_hold;     // keep wreq_val high with k_next after acceptance
  logic [WRQ-1:0] k_next;

  // Observations
  logic [NRQ-1:0] obs_nreq[8];
  int             obs_ncnt, obs_lat, obs_unstable, obs_busy, obs_acc_wait;
  logic [WRS-1:0] obs_wresp;
  bit             obs_to, obs_aborted, obs_rdy_after;

  function automatic logic [WRQ-1:0] mk_wreq(logic [2:0] t, logic [7:0] op, logic [31:0] a,
                                             logic [3:0] len, logic [127:0] d);
    return {t, op, a, len, d};
  endfunction

  // Reference: word i goes to line base + 4i, carrying write data word i (0 otherwise)
  function automatic logic [NRQ-1:0] exp_nreq(logic [2:0] t, logic [7:0] op, logic [31:0] a,
                                              logic [127:0] d, int i);
    logic [31:0] base, dw;
    base = a & 32'hFFFF_FFF0;
    dw   = (t == 3'd1) ? d[32*i +: 32] : 32'd0;
    return {t, op, base + 32'(4*i), 2'd0, dw};
  endfunction

  function automatic logic [WRS-1:0] exp_wresp(logic [2:0] t, logic [7:0] op, logic [127:0] line);
    return {t, op, 4'd0, (t == 3'd1) ? 128'd0 : line};
  endfunction

  function automatic void knobs_clear();
    for (int i = 0; i < 4; i++) begin k_nst[i] = 0; k_rdl[i] = 0; end
    k_wst = 0; k_abort = -1; k_hold = 1'b0;
  endfunction

  // Runs one line transaction as requester and narrow memory; called at a negedge, returns at a negedge.
  task automatic run_xact(input logic [WRQ-1:0] req);
    int nst[4], rdl[4];
    int wst, rcnt, cyc, idx;
    logic [NRQ-1:0] pn;
    bit pn_stall, got_w;
    nst = k_nst; rdl = k_rdl; wst = k_wst;
    rcnt = 0; pn = '0; pn_stall = 0; got_w = 0;
    obs_ncnt = 0; obs_lat = -1; obs_unstable = 0; obs_busy = 0; obs_acc_wait = 0;
    obs_wresp = '0; obs_to = 0; obs_aborted = 0; obs_rdy_after = 0;
    for (int i = 0; i < 8; i++) obs_nreq[i] = '0;
    wreq_val = 1'b1; wreq_msg = req;
    while (!wreq_rdy && obs_acc_wait < 50) begin @(negedge clk); obs_acc_wait++; end
    if (!wreq_rdy) begin obs_to = 1; wreq_val = 1'b0; return; end
    @(posedge clk); @(negedge clk);
    if (k_hold) wreq_msg = k_next; else wreq_val = 1'b0;
    cyc = 1;
    while (cyc < 300) begin
      if (wreq_rdy) obs_busy++;
      if (nreq_val) begin
        if (pn_stall && nreq_msg !== pn) obs_unstable++;
        pn  = nreq_msg;
        idx = (obs_ncnt < 4) ? obs_ncnt : 0;
        if (obs_ncnt < 4 && nst[idx] > 0) begin
          nreq_rdy = 1'b0; nst[idx]--; pn_stall = 1;
        end else begin
          nreq_rdy = 1'b1; pn_stall = 0;
          if (obs_ncnt < 8) obs_nreq[obs_ncnt] = nreq_msg;
          obs_ncnt++;
        end
      end else begin
        nreq_rdy = 1'b0; pn_stall = 0;
      end
      if (nresp_rdy) begin
        if (rcnt == k_abort) begin
          obs_aborted = 1; nresp_val = 1'b0; nreq_rdy = 1'b0; return;
        end
        idx = (rcnt < 4) ? rcnt : 0;
        if (rcnt < 4 && rdl[idx] > 0) begin
          nresp_val = 1'b0; rdl[idx]--;
        end else begin
          // random type/opaque: the translator must ignore them
          nresp_val = 1'b1;
          nresp_msg = {3'($urandom), 8'($urandom), 2'd0, k_line[32*idx +: 32]};
          rcnt++;
        end
      end else begin
        nresp_val = 1'b0;
      end
      if (wresp_val) begin
        if (!got_w) begin got_w = 1; obs_lat = cyc; obs_wresp = wresp_msg; end
        else if (wresp_msg !== obs_wresp) obs_unstable++;
        if (wst > 0) begin
          wresp_rdy = 1'b0; wst--;
        end else begin
          wresp_rdy = 1'b1;
          @(posedge clk); @(negedge clk);
          wresp_rdy = 1'b0; nreq_rdy = 1'b0; nresp_val = 1'b0;
          obs_rdy_after = wreq_rdy;
          return;
        end
      end else begin
        wresp_rdy = 1'b0;
      end
      @(negedge clk); cyc++;
    end
    obs_to = 1;
    nreq_rdy = 1'b0; nresp_val = 1'b0; wresp_rdy = 1'b0; wreq_val = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    wreq_val = 1'b0; wreq_msg = '0; wresp_rdy = 1'b0;
    nreq_rdy = 1'b0; nresp_val = 1'b0; nresp_msg = '0;
    @(negedge clk);
    checks++; if (wreq_rdy !== 1'b1)  begin failures++; $display("FAIL reset_wreq_rdy got %b exp 1", wreq_rdy); end
    checks++; if (nreq_val !== 1'b0)  begin failures++; $display("FAIL reset_nreq_val got %b exp 0", nreq_val); end
    checks++; if (nresp_rdy !== 1'b0) begin failures++; $display("FAIL reset_nresp_rdy got %b exp 0", nresp_rdy); end
    checks++; if (wresp_val !== 1'b0) begin failures++; $display("FAIL reset_wresp_val got %b exp 0", wresp_val); end
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({wreq_rdy, nreq_val, nresp_rdy, wresp_val} !== 4'b1000) begin
      failures++; $display("FAIL post_reset_outputs got %b exp 1000", {wreq_rdy, nreq_val, nresp_rdy, wresp_val});
    end
  endtask

  task automatic test_line_read();
    logic [WRQ-1:0] req;
    knobs_clear();
    k_line = {32'h44, 32'h33, 32'h22, 32'h11};
    req = mk_wreq(3'd0, 8'h5A, 32'h1004, 4'($urandom), {$urandom, $urandom, $urandom, $urandom});
    run_xact(req);
    checks++; if (obs_to || obs_ncnt != 4) begin failures++; $display("FAIL read_nreq_count got %0d exp 4 (timeout %0d)", obs_ncnt, obs_to); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_nreq[i] !== {3'd0, 8'h5A, 32'h1000 + 32'(4*i), 2'd0, 32'd0}) begin
        failures++; $display("FAIL read_nreq%0d got %h", i, obs_nreq[i]);
      end
    end
    checks++;
    if (obs_wresp !== {3'd0, 8'h5A, 4'd0, 128'h00000044_00000033_00000022_00000011}) begin
      failures++; $display("FAIL read_wresp got %h", obs_wresp);
    end
    checks++; if (obs_lat != 9) begin failures++; $display("FAIL read_latency got %0d exp 9", obs_lat); end
    checks++; if (obs_busy != 0) begin failures++; $display("FAIL read_wreq_rdy_busy got %0d exp 0", obs_busy); end
  endtask

  task automatic test_line_write();
    logic [127:0] d;
    knobs_clear();
    k_line = {$urandom, $urandom, $urandom, $urandom};
    d = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    run_xact(mk_wreq(3'd1, 8'h3C, 32'h2000, 4'd0, d));
    checks++; if (obs_to || obs_ncnt != 4) begin failures++; $display("FAIL write_nreq_count got %0d exp 4", obs_ncnt); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_nreq[i] !== exp_nreq(3'd1, 8'h3C, 32'h2000, d, i)) begin
        failures++; $display("FAIL write_nreq%0d got %h exp %h", i, obs_nreq[i], exp_nreq(3'd1, 8'h3C, 32'h2000, d, i));
      end
    end
    checks++;
    if (obs_wresp !== {3'd1, 8'h3C, 4'd0, 128'd0}) begin failures++; $display("FAIL write_wresp got %h", obs_wresp); end
  endtask

  task automatic test_backpressure();
    logic [31:0] a;
    logic [7:0]  op;
    knobs_clear();
    k_nst[2] = 3; k_rdl[0] = 5; k_wst = 4;
    k_line = {$urandom, $urandom, $urandom, $urandom};
    a = $urandom; op = 8'($urandom);
    run_xact(mk_wreq(3'd0, op, a, 4'd0, '0));
    checks++; if (obs_to || obs_ncnt != 4) begin failures++; $display("FAIL bp_nreq_count got %0d exp 4", obs_ncnt); end
    checks++; if (obs_unstable != 0) begin failures++; $display("FAIL bp_stability got %0d changes exp 0", obs_unstable); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_nreq[i] !== exp_nreq(3'd0, op, a, '0, i)) begin
        failures++; $display("FAIL bp_nreq%0d got %h exp %h", i, obs_nreq[i], exp_nreq(3'd0, op, a, '0, i));
      end
    end
    checks++;
    if (obs_wresp !== exp_wresp(3'd0, op, k_line)) begin
      failures++; $display("FAIL bp_wresp got %h exp %h", obs_wresp, exp_wresp(3'd0, op, k_line));
    end
    checks++; if (obs_lat != 17) begin failures++; $display("FAIL bp_latency got %0d exp 17", obs_lat); end
  endtask

  task automatic test_back_to_back();
    logic [WRQ-1:0] r1, r2;
    logic [127:0]   l2;
    knobs_clear();
    r1 = mk_wreq(3'd0, 8'h01, 32'h3000, 4'd0, '0);
    r2 = mk_wreq(3'd0, 8'h02, 32'h4008, 4'd0, '0);
    k_line = {$urandom, $urandom, $urandom, $urandom};
    l2 = {$urandom, $urandom, $urandom, $urandom};
    k_hold = 1'b1; k_next = r2;
    run_xact(r1);
    checks++; if (obs_busy != 0) begin failures++; $display("FAIL b2b_wreq_rdy_busy got %0d exp 0", obs_busy); end
    checks++;
    if (obs_wresp !== exp_wresp(3'd0, 8'h01, k_line)) begin failures++; $display("FAIL b2b_wresp1 got %h", obs_wresp); end
    checks++; if (obs_rdy_after !== 1'b1) begin failures++; $display("FAIL b2b_rdy_after got %b exp 1", obs_rdy_after); end
    k_hold = 1'b0; k_line = l2;
    run_xact(r2);
    checks++; if (obs_acc_wait != 0) begin failures++; $display("FAIL b2b_accept_wait got %0d exp 0", obs_acc_wait); end
    checks++;
    if (obs_wresp !== exp_wresp(3'd0, 8'h02, l2)) begin failures++; $display("FAIL b2b_wresp2 got %h exp %h", obs_wresp, exp_wresp(3'd0, 8'h02, l2)); end
    checks++; if (obs_nreq[0] !== exp_nreq(3'd0, 8'h02, 32'h4008, '0, 0)) begin failures++; $display("FAIL b2b_nreq0 got %h", obs_nreq[0]); end
  endtask

  task automatic test_reset_mid();
    knobs_clear();
    k_abort = 1;
    k_line = {$urandom, $urandom, $urandom, $urandom};
    run_xact(mk_wreq(3'd0, 8'h77, 32'h5000, 4'd0, '0));
    checks++;
    if (!obs_aborted || nresp_rdy !== 1'b1) begin failures++; $display("FAIL rst_mid_reach_nwait got aborted=%0d rdy=%b exp 1/1", obs_aborted, nresp_rdy); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({wreq_rdy, nreq_val, nresp_rdy, wresp_val} !== 4'b1000) begin
      failures++; $display("FAIL rst_mid_outputs got %b exp 1000", {wreq_rdy, nreq_val, nresp_rdy, wresp_val});
    end
    @(negedge clk); reset_n = 1'b1;
    nresp_val = 1'b1; nresp_msg = {3'd0, 8'h77, 2'd0, 32'hBAD0BAD0};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({wreq_rdy, nreq_val, nresp_rdy, wresp_val} !== 4'b1000) begin
        failures++; $display("FAIL rst_stray_resp cyc%0d got %b exp 1000", c, {wreq_rdy, nreq_val, nresp_rdy, wresp_val});
      end
    end
    nresp_val = 1'b0;
    knobs_clear();
    k_line = {$urandom, $urandom, $urandom, $urandom};
    run_xact(mk_wreq(3'd0, 8'h78, 32'h6000, 4'd0, '0));
    checks++;
    if (obs_to || obs_wresp !== exp_wresp(3'd0, 8'h78, k_line) || obs_lat != 9) begin
      failures++; $display("FAIL rst_fresh_read got %h lat %0d exp %h lat 9", obs_wresp, obs_lat, exp_wresp(3'd0, 8'h78, k_line));
    end
  endtask

  task automatic test_random();
    logic [2:0]   t;
    logic [7:0]   op;
    logic [31:0]  a;
    logic [127:0] d;
    int           exp_lat;
    for (int n = 0; n < 16; n++) begin
      knobs_clear();
      t  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
      op = 8'($urandom); a = $urandom;
      d  = {$urandom, $urandom, $urandom, $urandom};
      k_line = {$urandom, $urandom, $urandom, $urandom};
      exp_lat = 9;
      for (int i = 0; i < 4; i++) begin
        k_nst[i] = $urandom_range(0, 2); k_rdl[i] = $urandom_range(0, 2);
        exp_lat += k_nst[i] + k_rdl[i];
      end
      k_wst = $urandom_range(0, 3);
      run_xact(mk_wreq(t, op, a, 4'($urandom), d));
      checks++; if (obs_to || obs_ncnt != 4) begin failures++; $display("FAIL rnd%0d_nreq_count got %0d exp 4", n, obs_ncnt); end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_nreq[i] !== exp_nreq(t, op, a, d, i)) begin
          failures++; $display("FAIL rnd%0d_nreq%0d got %h exp %h", n, i, obs_nreq[i], exp_nreq(t, op, a, d, i));
        end
      end
      checks++;
      if (obs_wresp !== exp_wresp(t, op, k_line)) begin
        failures++; $display("FAIL rnd%0d_wresp got %h exp %h", n, obs_wresp, exp_wresp(t, op, k_line));
      end
      checks++; if (obs_lat != exp_lat) begin failures++; $display("FAIL rnd%0d_latency got %0d exp %0d", n, obs_lat, exp_lat); end
      checks++; if (obs_unstable != 0) begin failures++; $display("FAIL rnd%0d_stability got %0d exp 0", n, obs_unstable); end
    end
  endtask

  initial begin
    knobs_clear();
    k_line = '0; k_next = '0;
    test_reset();
    test_line_read();
    test_line_write();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
